// File: rtl/tnn_feature_packer.sv
// tnn_feature_packer: quantizes a serial stream of raw feature samples to
// Q_W bits, packs N_FEAT of them into one frame for the TNN neuron inputs,
// and holds the frame until the consumer takes it. It also checks framing
// against in_last and counts the frames it emits.
module tnn_feature_packer #(
  parameter int IN_W   = 8,
  parameter int N_FEAT = 5,
  parameter int Q_W    = 3,
  parameter int SHIFT  = 5,
  parameter int OFFSET = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_W-1:0]         in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_FEAT*Q_W-1:0]   out_vec,
  output logic                    frame_err,
  output logic [15:0]             frame_cnt
);

  localparam int                IDX_W    = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_FEAT - 1);
  localparam logic [IN_W-1:0]   QMAX     = IN_W'((1 << Q_W) - 1);
  localparam logic [IN_W-1:0]   OFS      = IN_W'(OFFSET);

  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [N_FEAT*Q_W-1:0]   asm_q, asm_d;
  logic [N_FEAT*Q_W-1:0]   out_vec_q, out_vec_d;
  logic                    out_valid_q, out_valid_d;
  logic                    frame_err_q, frame_err_d;
  logic [15:0]             frame_cnt_q, frame_cnt_d;

  logic [IN_W-1:0]         diff;
  logic [Q_W-1:0]          q;
  logic [N_FEAT*Q_W-1:0]   asm_wr;
  logic                    at_last;
  logic                    accept;

  assign at_last   = (idx_q == LAST_IDX);
  // Only the completing sample has to wait for a stalled output; the
  // earlier ones land in the assembly register, which is separate from out_vec.
  assign in_ready  = !rst && !(at_last && out_valid_q && !out_ready);
  assign accept    = in_valid && in_ready;

  assign out_vec   = out_vec_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;
  assign frame_cnt = frame_cnt_q;

  // Quantize: clamp below OFFSET to 0, shift down, saturate to the Q_W range.
  always_comb begin
    diff = '0;
    q    = '0;
    if (in_data >= OFS) begin
      diff = (in_data - OFS) >> SHIFT;
      if (diff > QMAX) q = '1;
      else             q = diff[Q_W-1:0];
    end
  end

  // Assembly register with the current sample merged into field idx.
  always_comb begin
    asm_wr = asm_q;
    asm_wr[idx_q*Q_W +: Q_W] = q;
  end

  // Next-state: assembly, framing checks, output hold/replace and frame count.
  always_comb begin
    idx_d       = idx_q;
    asm_d       = asm_q;
    out_vec_d   = out_vec_q;
    out_valid_d = out_valid_q;
    frame_err_d = 1'b0;
    frame_cnt_d = frame_cnt_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (accept) begin
      if (at_last) begin
        // A completing frame overrides the clear above, so a frame taken
        // and a frame completed on the same edge gives no bubble.
        out_vec_d   = asm_wr;
        out_valid_d = 1'b1;
        frame_cnt_d = frame_cnt_q + 16'd1;
        idx_d       = '0;
        asm_d       = '0;
        frame_err_d = !in_last;
      end else if (in_last) begin
        // Early end of frame: drop the partial frame, including this sample.
        idx_d       = '0;
        asm_d       = '0;
        frame_err_d = 1'b1;
      end else begin
        asm_d = asm_wr;
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  // State registers; reset drops any partial or pending frame immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q       <= '0;
      asm_q       <= '0;
      out_vec_q   <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      idx_q       <= idx_d;
      asm_q       <= asm_d;
      out_vec_q   <= out_vec_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_tnn_feature_packer.sv
// Bench for tnn_feature_packer: table of frames with expected packed vectors,
// a scoreboard queue popped whenever a frame is handed to the consumer, and
// hand-written sequences for backpressure, framing errors and reset.
module tb_tnn_feature_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last, out_valid, out_ready, frame_err;
  logic [7:0]  in_data;
  logic [14:0] out_vec;
  logic [15:0] frame_cnt;

  logic        s_in_valid, s_in_ready, s_in_last, s_out_valid, s_out_ready, s_frame_err;
  logic [7:0]  s_in_data;
  logic [14:0] s_out_vec;
  logic [15:0] s_frame_cnt;

  int checks = 0;
  int errors = 0;
  logic [14:0] sb[$];
  logic [14:0] exp_v;
  int exp_cnt;
  int cyc;

  typedef struct {
    logic [4:0][7:0] smp;
    logic [14:0]     exp;
  } vec_t;
  vec_t tbl[5];
  vec_t stbl[2];

  always #5 clk = ~clk;

  tnn_feature_packer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_vec(out_vec), .frame_err(frame_err),
    .frame_cnt(frame_cnt));

  tnn_feature_packer #(.SHIFT(3)) dut_s (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .in_last(s_in_last), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_vec(s_out_vec), .frame_err(s_frame_err),
    .frame_cnt(s_frame_cnt));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Drive one sample and hold it until accepted (bounded); returns cycles taken.
  task automatic send(input logic [7:0] d, input logic last, output int n);
    bit done;
    done = 1'b0;
    n = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    while (!done && n < 50) begin
      @(negedge clk); done = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout data=%0d", d);
    end
  endtask

  task automatic send_frame(input vec_t v, input logic last_ok);
    int n;
    sb.push_back(v.exp);
    for (int k = 0; k < 5; k++) send(v.smp[k], (k == 4) ? last_ok : 1'b0, n);
  endtask

  // Consumer side: a frame transfers on the next edge when valid && ready.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_frame actual=%0h expected=none", out_vec);
      end else begin
        exp_v = sb.pop_front();
        chk("out_vec", {17'd0, out_vec}, {17'd0, exp_v});
      end
    end
  end

  initial begin
    tbl[0].smp = {8'd160, 8'd128, 8'd96, 8'd64, 8'd32};   tbl[0].exp = 15'b101_100_011_010_001;
    tbl[1].smp = {8'd33, 8'd224, 8'd255, 8'd31, 8'd0};    tbl[1].exp = 15'b001_111_111_000_000;
    tbl[2].smp = {8'd255, 8'd255, 8'd255, 8'd255, 8'd255}; tbl[2].exp = 15'h7fff;
    tbl[3].smp = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0};          tbl[3].exp = 15'h0000;
    tbl[4].smp = {8'd250, 8'd150, 8'd50, 8'd200, 8'd100}; tbl[4].exp = 15'b111_100_001_110_011;
    stbl[0].smp = {8'd63, 8'd8, 8'd7, 8'd0, 8'd255};      stbl[0].exp = 15'b111_001_000_000_111;
    stbl[1].smp = {8'd47, 8'd56, 8'd40, 8'd16, 8'd24};    stbl[1].exp = 15'b101_111_101_010_011;

    rst = 1'b1; in_valid = 0; in_data = 0; in_last = 0; out_ready = 1;
    s_in_valid = 0; s_in_data = 0; s_in_last = 0; s_out_ready = 1;
    exp_cnt = 0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_vec", out_vec, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Table frames, streamed back to back with the consumer always ready.
    for (int i = 0; i < 5; i++) begin
      send_frame(tbl[i], 1'b1);
      exp_cnt++;
      chk("lat_out_valid", out_valid, 1);
      chk("frame_cnt", frame_cnt, exp_cnt);
      chk("clean_frame_err", frame_err, 0);
    end

    // Backpressure: tbl[4] stays pending, next frame's first four go in.
    out_ready = 1'b0;
    sb.push_back(tbl[0].exp);
    for (int k = 0; k < 4; k++) begin
      send(tbl[0].smp[k], 1'b0, cyc);
      chk("stall_accept_cycles", cyc, 1);
    end
    in_valid = 1'b1; in_data = tbl[0].smp[4]; in_last = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_vec", out_vec, tbl[4].exp);
      chk("stall_out_valid", out_valid, 1);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0; in_last = 1'b0;
    exp_cnt++;
    chk("b2b_out_valid", out_valid, 1);
    chk("b2b_out_vec", out_vec, tbl[0].exp);
    chk("b2b_frame_cnt", frame_cnt, exp_cnt);

    // Early last on the third sample.
    send(8'd32, 1'b0, cyc);
    send(8'd64, 1'b0, cyc);
    send(8'd96, 1'b1, cyc);
    chk("early_frame_err", frame_err, 1);
    chk("early_out_valid", out_valid, 0);
    chk("early_frame_cnt", frame_cnt, exp_cnt);
    @(posedge clk); #1;
    chk("early_err_pulse", frame_err, 0);
    send_frame(tbl[1], 1'b1);
    exp_cnt++;
    chk("after_early_cnt", frame_cnt, exp_cnt);
    chk("after_early_err", frame_err, 0);

    // Missing last: frame still emitted, error coincident with out_valid.
    send_frame(tbl[2], 1'b0);
    exp_cnt++;
    chk("miss_out_valid", out_valid, 1);
    chk("miss_frame_err", frame_err, 1);
    chk("miss_frame_cnt", frame_cnt, exp_cnt);
    @(posedge clk); #1;
    chk("miss_err_pulse", frame_err, 0);

    // Reset with a pending frame and a partial frame in assembly.
    out_ready = 1'b0;
    send_frame(tbl[3], 1'b1);
    send(8'd255, 1'b0, cyc);
    send(8'd255, 1'b0, cyc);
    send(8'd255, 1'b0, cyc);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_frame_cnt", frame_cnt, 0);
    chk("arst_out_vec", out_vec, 0);
    chk("arst_in_ready", in_ready, 0);
    sb.delete();
    exp_cnt = 0;
    @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
    send_frame(tbl[4], 1'b1);
    exp_cnt++;
    chk("post_rst_out_vec", out_vec, tbl[4].exp);
    chk("post_rst_frame_cnt", frame_cnt, exp_cnt);
    chk("post_rst_frame_err", frame_err, 0);

    // SHIFT=3 instance: saturation and field order.
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 5; k++) begin
        s_in_valid = 1'b1; s_in_data = stbl[i].smp[k]; s_in_last = (k == 4);
        @(negedge clk);
        chk("sat_in_ready", s_in_ready, 1);
        @(posedge clk); #1;
      end
      s_in_valid = 1'b0; s_in_last = 1'b0;
      chk("sat_out_valid", s_out_valid, 1);
      chk("sat_out_vec", s_out_vec, stbl[i].exp);
      chk("sat_frame_cnt", s_frame_cnt, i + 1);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
